// File: rtl/goertz_run_scheduler.sv
// Run scheduler for the dual-Goertzel datapath: fetches coefficient pairs, launches both cores, waits for both.
// Optional watchdog enabled by defining GOERTZ_SCHED_TIMEOUT_EN.
module goertz_run_scheduler #(
    parameter int NUM_RUNS    = 10,
    parameter int RUN_W       = 9,
    parameter int D_W         = 16,
    parameter int CAPT_DLY    = 1,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             block_start,
    output logic             coeffs_rq,
    input  logic             coeff_d_ready,
    input  logic [D_W-1:0]   sin_in,
    input  logic [D_W-1:0]   cos_in,
    output logic [D_W-1:0]   coeff_a_sin,
    output logic [D_W-1:0]   coeff_a_cos,
    output logic [D_W-1:0]   coeff_b_sin,
    output logic [D_W-1:0]   coeff_b_cos,
    output logic             core_a_start,
    output logic             core_b_start,
    input  logic             core_a_done,
    input  logic             core_b_done,
    output logic [RUN_W-1:0] run_idx,
    output logic             busy,
    output logic             block_done,
    output logic             err_overrun,
    output logic             err_timeout
);

    typedef enum logic [3:0] {
        IDLE, REQ_A, WAIT_A, CAP_A, REQ_B, WAIT_B, CAP_B, LAUNCH, RUN, NEXT
    } state_t;

    localparam logic [RUN_W-1:0] LAST_IDX = RUN_W'(NUM_RUNS - 2);
    localparam logic [1:0]       CAP_LAST = 2'(CAPT_DLY - 1);

    state_t     state, state_n;
    logic [1:0] cap_cnt;
    logic       done_a, done_b;
    logic       done_a_nx, done_b_nx;
    logic       cap_a, cap_b, launch;
    logic       last_pair;

    assign done_a_nx    = done_a | core_a_done;
    assign done_b_nx    = done_b | core_b_done;
    assign last_pair    = (run_idx == LAST_IDX);
    assign busy         = (state != IDLE);
    assign core_a_start = launch;
    assign core_b_start = launch;

`ifdef GOERTZ_SCHED_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    logic [WD_W-1:0] wd_cnt;
    logic            wd_active, wd_hit;

    assign wd_active = (state == WAIT_A) || (state == WAIT_B) || (state == RUN);
    assign wd_hit    = wd_active && (wd_cnt == WD_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wd_cnt      <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (state_n != state) wd_cnt <= '0;
            else if (wd_active)   wd_cnt <= wd_cnt + 1'b1;
            if (wd_hit) err_timeout <= 1'b1;
        end
    end
`else
    assign err_timeout = 1'b0;
`endif

    always_comb begin
        state_n   = state;
        coeffs_rq = 1'b0;
        launch    = 1'b0;
        cap_a     = 1'b0;
        cap_b     = 1'b0;
        case (state)
            // a start coinciding with block_done is treated as arriving while busy
            IDLE:   if (block_start && !block_done) state_n = REQ_A;
            REQ_A:  begin coeffs_rq = 1'b1; state_n = WAIT_A; end
            WAIT_A: if (coeff_d_ready) state_n = CAP_A;
            CAP_A:  if (cap_cnt == CAP_LAST) begin cap_a = 1'b1; state_n = REQ_B; end
            REQ_B:  begin coeffs_rq = 1'b1; state_n = WAIT_B; end
            WAIT_B: if (coeff_d_ready) state_n = CAP_B;
            CAP_B:  if (cap_cnt == CAP_LAST) begin cap_b = 1'b1; state_n = LAUNCH; end
            LAUNCH: begin launch = 1'b1; state_n = RUN; end
            RUN:    if (done_a_nx && done_b_nx) state_n = NEXT;
            NEXT:   state_n = last_pair ? IDLE : REQ_A;
            default: state_n = IDLE;
        endcase
`ifdef GOERTZ_SCHED_TIMEOUT_EN
        if (wd_hit) state_n = IDLE;
`endif
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state       <= IDLE;
            run_idx     <= '0;
            cap_cnt     <= '0;
            done_a      <= 1'b0;
            done_b      <= 1'b0;
            coeff_a_sin <= '0;
            coeff_a_cos <= '0;
            coeff_b_sin <= '0;
            coeff_b_cos <= '0;
            block_done  <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            state      <= state_n;
            block_done <= (state == NEXT) && last_pair;

            if (state == IDLE && state_n == REQ_A)  run_idx <= '0;
            else if (state == NEXT && !last_pair)   run_idx <= run_idx + RUN_W'(2);

            // capture delay counter restarts on every state change
            if (state_n != state)                     cap_cnt <= '0;
            else if (state == CAP_A || state == CAP_B) cap_cnt <= cap_cnt + 1'b1;

            if (launch) begin
                done_a <= 1'b0;
                done_b <= 1'b0;
            end else if (state == RUN) begin
                done_a <= done_a_nx;
                done_b <= done_b_nx;
            end

            if (cap_a) begin
                coeff_a_sin <= sin_in;
                coeff_a_cos <= cos_in;
            end
            if (cap_b) begin
                coeff_b_sin <= sin_in;
                coeff_b_cos <= cos_in;
            end

            if (block_start && (busy || block_done)) err_overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_goertz_run_scheduler.sv
// Directed bench for goertz_run_scheduler: per-launch vector table plus hand sequences for
// done ordering, overrun, mid-block reset and a CAPT_DLY=3 instance with per-cycle bank data.
module tb_goertz_run_scheduler;

    logic        sys_clk, sys_rst_n;
    logic        block_start, coeffs_rq, coeff_d_ready;
    logic [15:0] sin_in, cos_in;
    logic [15:0] coeff_a_sin, coeff_a_cos, coeff_b_sin, coeff_b_cos;
    logic        core_a_start, core_b_start, core_a_done, core_b_done;
    logic [8:0]  run_idx;
    logic        busy, block_done, err_overrun, err_timeout;

    logic        block_start3, coeffs_rq3, rdy3;
    logic [15:0] dat3, cos3;
    logic [15:0] a_sin3, a_cos3, b_sin3, b_cos3;
    logic        a_start3, b_start3, done3;
    logic [8:0]  run_idx3;
    logic        busy3, block_done3, ovr3, tmo3;

    goertz_run_scheduler u_dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .block_start(block_start),
        .coeffs_rq(coeffs_rq), .coeff_d_ready(coeff_d_ready),
        .sin_in(sin_in), .cos_in(cos_in),
        .coeff_a_sin(coeff_a_sin), .coeff_a_cos(coeff_a_cos),
        .coeff_b_sin(coeff_b_sin), .coeff_b_cos(coeff_b_cos),
        .core_a_start(core_a_start), .core_b_start(core_b_start),
        .core_a_done(core_a_done), .core_b_done(core_b_done),
        .run_idx(run_idx), .busy(busy), .block_done(block_done),
        .err_overrun(err_overrun), .err_timeout(err_timeout)
    );

    goertz_run_scheduler #(.CAPT_DLY(3)) u_dut3 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .block_start(block_start3),
        .coeffs_rq(coeffs_rq3), .coeff_d_ready(rdy3),
        .sin_in(dat3), .cos_in(cos3),
        .coeff_a_sin(a_sin3), .coeff_a_cos(a_cos3),
        .coeff_b_sin(b_sin3), .coeff_b_cos(b_cos3),
        .core_a_start(a_start3), .core_b_start(b_start3),
        .core_a_done(done3), .core_b_done(done3),
        .run_idx(run_idx3), .busy(busy3), .block_done(block_done3),
        .err_overrun(ovr3), .err_timeout(tmo3)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // bank model: ack one cycle after rq, request k returns sin=0x1000+k, cos=0x2000+k
    logic [15:0] bk;
    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            coeff_d_ready <= 1'b0; bk <= '0; sin_in <= '0; cos_in <= '0;
        end else begin
            coeff_d_ready <= coeffs_rq;
            if (coeffs_rq) begin
                sin_in <= 16'h1000 + bk;
                cos_in <= 16'h2000 + bk;
                bk     <= bk + 16'd1;
            end
        end
    end

    // core models: done pulse dly cycles after the edge sampling start
    int dly_a = 3, dly_b = 3;
    int ta, tb;
    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ta <= 0; tb <= 0;
        end else begin
            if (core_a_start) ta <= dly_a; else if (ta != 0) ta <= ta - 1;
            if (core_b_start) tb <= dly_b; else if (tb != 0) tb <= tb - 1;
        end
    end
    assign core_a_done = (ta == 1);
    assign core_b_done = (tb == 1);

    // second instance: bank data changes every cycle, cores finish one cycle after launch
    assign cos3 = ~dat3;
    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            dat3 <= 16'h3000; rdy3 <= 1'b0; done3 <= 1'b0;
        end else begin
            dat3  <= dat3 + 16'd1;
            rdy3  <= coeffs_rq3;
            done3 <= a_start3;
        end
    end

    typedef struct {
        int run_idx;
        int ka;
        int kb;
    } vec_t;
    vec_t tbl[5];

    int n_cmp = 0, n_fail = 0;
    int cyc = 0, rq_cnt = 0, last_rq_cyc = -100, last_done_cyc = -100, launch_cnt = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // every negedge goes through here so the protocol monitor sees each cycle
    task automatic tick();
        @(negedge sys_clk);
        cyc++;
        if (core_a_start) begin
            chk("start_b_with_a", core_b_start, 1);
            launch_cnt++;
        end
        if (coeffs_rq) begin
            if (rq_cnt > 0) chk("rq_gap_ge3", int'((cyc - last_rq_cyc) >= 3), 1);
            if (rq_cnt > 0 && rq_cnt % 2 == 0) chk("rq_after_done", cyc - last_done_cyc, 2);
            rq_cnt++;
            last_rq_cyc = cyc;
        end
        if (core_a_done || core_b_done) last_done_cyc = cyc;
    endtask

    task automatic run_block(input int base, input int dla, input int dlb,
                             input bit ovr_run, input bit ovr_done);
        int c;
        bit got;
        dly_a = dla; dly_b = dlb; rq_cnt = 0; launch_cnt = 0;
        block_start = 1'b1;
        tick();
        block_start = 1'b0;
        chk("rq_after_start", coeffs_rq, 1);
        chk("busy_after_start", busy, 1);
        for (int i = 0; i < 5; i++) begin
            c = 0; got = 0;
            while (!got && c < 100) begin
                tick(); c++;
                if (core_a_start) got = 1;
            end
            chk("launch_seen", got, 1);
            if (i == 0) chk("launch_latency", c, 6);
            chk("run_idx", run_idx, tbl[i].run_idx);
            chk("a_sin", coeff_a_sin, 'h1000 + base + tbl[i].ka);
            chk("a_cos", coeff_a_cos, 'h2000 + base + tbl[i].ka);
            chk("b_sin", coeff_b_sin, 'h1000 + base + tbl[i].kb);
            chk("b_cos", coeff_b_cos, 'h2000 + base + tbl[i].kb);
            if (ovr_run && i == 2) begin
                chk("overrun_pre", err_overrun, 0);
                block_start = 1'b1;
                tick();
                block_start = 1'b0;
                chk("overrun_set", err_overrun, 1);
            end
        end
        c = 0; got = 0;
        while (!got && c < 100) begin
            tick(); c++;
            if (block_done) got = 1;
        end
        chk("block_done_seen", got, 1);
        chk("busy_at_block_done", busy, 0);
        chk("block_done_latency", cyc - last_done_cyc, 2);
        chk("rq_per_block", rq_cnt, 10);
        chk("launches_per_block", launch_cnt, 5);
        if (ovr_done) begin
            chk("overrun_pre_done", err_overrun, 0);
            block_start = 1'b1;
        end
        tick();
        block_start = 1'b0;
        chk("block_done_one_cycle", block_done, 0);
        chk("idle_after_block", busy, 0);
        if (ovr_done) chk("overrun_at_done", err_overrun, 1);
        if (ovr_run) chk("overrun_sticky", err_overrun, 1);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_rq", coeffs_rq, 0);
        chk("rst_busy", busy, 0);
        chk("rst_run_idx", run_idx, 0);
        chk("rst_a_sin", coeff_a_sin, 0);
        chk("rst_a_cos", coeff_a_cos, 0);
        chk("rst_b_sin", coeff_b_sin, 0);
        chk("rst_b_cos", coeff_b_cos, 0);
        chk("rst_start", core_a_start, 0);
        chk("rst_block_done", block_done, 0);
        chk("rst_overrun", err_overrun, 0);
        chk("rst_timeout", err_timeout, 0);
    endtask

    task automatic run3();
        int c, acks, launches, rq3, last3;
        logic [15:0] exp_a, exp_b, inv;
        c = 0; acks = 0; launches = 0; rq3 = 0; last3 = -100;
        exp_a = '0; exp_b = '0;
        block_start3 = 1'b1;
        while (!block_done3 && c < 400) begin
            tick(); c++;
            block_start3 = 1'b0;
            if (coeffs_rq3) begin
                if (rq3 > 0) chk("rq3_gap_ge3", int'((cyc - last3) >= 3), 1);
                rq3++;
                last3 = cyc;
            end
            if (rdy3) begin
                if (acks % 2 == 0) exp_a = dat3 + 16'd3;
                else               exp_b = dat3 + 16'd3;
                acks++;
            end
            if (a_start3) begin
                chk("d3_a_sin", a_sin3, exp_a);
                inv = ~exp_a;
                chk("d3_a_cos", a_cos3, inv);
                chk("d3_b_sin", b_sin3, exp_b);
                chk("d3_run_idx", run_idx3, 2 * launches);
                launches++;
            end
        end
        chk("d3_block_done", block_done3, 1);
        chk("d3_launches", launches, 5);
        chk("d3_rq_count", rq3, 10);
    endtask

    initial begin
        for (int i = 0; i < 5; i++) begin
            tbl[i].run_idx = 2 * i;
            tbl[i].ka      = 2 * i;
            tbl[i].kb      = 2 * i + 1;
        end
        sys_rst_n = 1'b0; block_start = 1'b0; block_start3 = 1'b0;
        tick(); tick();
        chk_reset_outputs();
        sys_rst_n = 1'b1;
        tick();

        run_block(0, 3, 3, 0, 0);          // nominal, both dones together
        chk("no_overrun_nominal", err_overrun, 0);
        run_block(10, 7, 2, 0, 0);         // core B finishes 5 cycles before A
        run_block(20, 3, 3, 1, 0);         // block_start during RUN

        // reset in WAIT_B, then restart from run 0
        rq_cnt = 0;
        block_start = 1'b1;
        tick();
        block_start = 1'b0;
        repeat (4) tick();
        chk("in_wait_b_busy", busy, 1);
        chk("in_wait_b_no_rq", coeffs_rq, 0);
        chk("in_wait_b_a_sin", coeff_a_sin, 'h1000 + 30);
        sys_rst_n = 1'b0;
        #1;
        chk_reset_outputs();
        tick();
        sys_rst_n = 1'b1;
        tick();
        run_block(0, 1, 4, 0, 1);          // also block_start coincident with block_done

        run3();
        chk("timeout_off", err_timeout, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
